// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative radix-2 divider.
package div_pkg;

  localparam int unsigned DivMaxWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_t;

  // Iteration counter must hold WIDTH-1 down to 0.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Caller sign-extends into DivMaxWidth bits; low WIDTH bits of the result are the magnitude,
  // so the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [DivMaxWidth-1:0] div_abs(input logic [DivMaxWidth-1:0] value,
                                                     input logic                   is_signed);
    return (is_signed && value[DivMaxWidth-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   prem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   prem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted   = {prem, dvd_bit};
    diff      = shifted - {2'b00, divisor};
    q_bit     = ~diff[WIDTH+1];
    prem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider with fixed WIDTH+1 cycle latency and valid/ready handshakes.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int unsigned CntW = div_cnt_w(WIDTH);

  div_state_t state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   prem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;

  logic                   accept;
  logic                   calc_last;
  logic [DivMaxWidth-1:0] dvd_ext;
  logic [DivMaxWidth-1:0] dsr_ext;
  logic [WIDTH-1:0]       dvd_mag;
  logic [WIDTH-1:0]       dsr_mag;
  logic [WIDTH:0]         step_prem;
  logic                   step_qbit;

  assign accept    = in_valid & (state_q == StIdle) & ~flush;
  assign calc_last = (cnt_q == '0);

  always_comb begin
    dvd_ext              = {DivMaxWidth{in_signed & dividend[WIDTH-1]}};
    dvd_ext[WIDTH-1:0]   = dividend;
    dsr_ext              = {DivMaxWidth{in_signed & divisor[WIDTH-1]}};
    dsr_ext[WIDTH-1:0]   = divisor;
    dvd_mag              = WIDTH'(div_abs(dvd_ext, in_signed));
    dsr_mag              = WIDTH'(div_abs(dsr_ext, in_signed));
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem     (prem_q),
    .dvd_bit  (quo_q[WIDTH-1]),
    .divisor  (dsr_q),
    .prem_next(step_prem),
    .q_bit    (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (in_valid) state_d = StCalc;
        StCalc:  if (calc_last) state_d = StFix;
        StFix:   state_d = StDone;
        StDone:  if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
  end

  // quo_q starts as the dividend magnitude; its MSB feeds each step while quotient bits fill from
  // the LSB, so after WIDTH steps it holds the quotient magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      dvd_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
    end else if (accept) begin
      cnt_q   <= CntW'(WIDTH - 1);
      prem_q  <= '0;
      quo_q   <= dvd_mag;
      dsr_q   <= dsr_mag;
      dvd_q   <= dividend;
      q_neg_q <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_q <= in_signed & dividend[WIDTH-1];
      dz_q    <= (divisor == '0);
    end else if (!flush && state_q == StCalc) begin
      cnt_q  <= calc_last ? '0 : cnt_q - 1'b1;
      prem_q <= step_prem;
      quo_q  <= {quo_q[WIDTH-2:0], step_qbit};
    end else if (!flush && state_q == StFix) begin
      if (dz_q) begin
        quotient_q  <= '1;
        remainder_q <= dvd_q;
      end else begin
        quotient_q  <= q_neg_q ? -quo_q : quo_q;
        remainder_q <= r_neg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
      end
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed and random bench for div_iter at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, rst8, flush, in_signed, out_ready, iv32, iv8;
  logic [31:0] dividend, divisor;

  logic        ir32, ov32, busy32, ir8, ov8, busy8;
  logic [31:0] q32, r32;
  logic [7:0]  q8, r8;

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor), .out_valid(ov32),
    .out_ready(out_ready), .quotient(q32), .remainder(r32), .busy(busy32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .flush(flush), .in_valid(iv8), .in_ready(ir8),
    .in_signed(in_signed), .dividend(dividend[7:0]), .divisor(divisor[7:0]), .out_valid(ov8),
    .out_ready(out_ready), .quotient(q8), .remainder(r8), .busy(busy8)
  );

  // Selects which instance the shared tasks drive and observe.
  bit          sel8;
  logic        v_ir, v_ov, v_busy;
  logic [31:0] v_q, v_r;
  assign v_ir   = sel8 ? ir8 : ir32;
  assign v_ov   = sel8 ? ov8 : ov32;
  assign v_busy = sel8 ? busy8 : busy32;
  assign v_q    = sel8 ? {24'h0, q8} : q32;
  assign v_r    = sel8 ? {24'h0, r8} : r32;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   da, db;
    if (b == 8'h0) begin
      e.q = 32'h0000_00FF;
      e.r = {24'h0, a};
    end else begin
      da  = sgn ? int'($signed(a)) : int'(a);
      db  = sgn ? int'($signed(b)) : int'(b);
      e.q = {24'h0, 8'(da / db)};
      e.r = {24'h0, 8'(da % db)};
    end
    return e;
  endfunction

  task automatic op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er, input int lat);
    int   n;
    exp_t e;
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    sb.push_back({eq, er});
    check("in_ready_pre", 32'(v_ir), 32'd1);
    if (sel8) iv8 = 1'b1;
    else iv32 = 1'b1;
    @(posedge clk); #1;
    iv8  = 1'b0;
    iv32 = 1'b0;
    n    = 0;
    while (!v_ov && n < lat + 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    e = sb.pop_front();
    check("quotient", v_q, e.q);
    check("remainder", v_r, e.r);
    if (out_ready) begin
      @(posedge clk); #1;
      check("in_ready_after", 32'(v_ir), 32'd1);
      check("out_valid_drop", 32'(v_ov), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hq, hr;
    int          rises;
    logic [7:0]  a8, b8;
    logic        s8;
    exp_t        e8;

    rst32 = 1'b1; rst8 = 1'b1; flush = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
    iv32 = 1'b0; iv8 = 1'b0; dividend = '0; divisor = '0; sel8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir32), 32'd1);
    check("rst_out_valid", 32'(ov32), 32'd0);
    check("rst_busy", 32'(busy32), 32'd0);
    check("rst_quotient", q32, 32'd0);
    check("rst_remainder", r32, 32'd0);
    rst32 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    op(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 33);
    op(1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 33);

    // Back-pressure: result held while out_ready is low.
    out_ready = 1'b0;
    op(1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 33);
    hq = q32;
    hr = r32;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(ov32), 32'd1);
      check("stall_q", q32, 32'd111);
      check("stall_r", r32, 32'd1);
      check("stall_in_ready", 32'(ir32), 32'd0);
    end
    check("stall_hold_q", q32, hq);
    check("stall_hold_r", r32, hr);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", 32'(ir32), 32'd1);

    // Flush mid-CALC drops the operation.
    in_signed = 1'b0; dividend = 32'd5000; divisor = 32'd3;
    iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_pre_busy", 32'(busy32), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 32'(ir32), 32'd1);
    check("flush_busy", 32'(busy32), 32'd0);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32) rises++;
    end
    check("flush_no_valid", 32'(rises), 32'd0);

    // Flush together with in_valid: request must be refused.
    flush = 1'b1; iv32 = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; iv32 = 1'b0;
    check("flush_refuse", 32'(busy32), 32'd0);
    op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // WIDTH=8 instance: corner cases then random operands against the model.
    sel8 = 1'b1;
    e8 = ref8(1'b1, 8'h80, 8'hFF);
    op(1'b1, 32'h80, 32'hFF, e8.q, e8.r, 9);
    e8 = ref8(1'b1, 8'h85, 8'h00);
    op(1'b1, 32'h85, 32'h00, e8.q, e8.r, 9);
    for (int i = 0; i < 24; i++) begin
      a8 = 8'($urandom);
      b8 = (i % 7 == 3) ? 8'h00 : 8'($urandom);
      s8 = 1'($urandom);
      e8 = ref8(s8, a8, b8);
      op(s8, {24'h0, a8}, {24'h0, b8}, e8.q, e8.r, 9);
    end

    // Asynchronous reset mid-CALC.
    in_signed = 1'b0; dividend = 32'd200; divisor = 32'd7;
    iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst8_pre_busy", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    #1;
    check("rst8_in_ready", 32'(ir8), 32'd1);
    check("rst8_out_valid", 32'(ov8), 32'd0);
    check("rst8_busy", 32'(busy8), 32'd0);
    check("rst8_quotient", {24'h0, q8}, 32'd0);
    check("rst8_remainder", {24'h0, r8}, 32'd0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(posedge clk); #1;
    e8 = ref8(1'b0, 8'd200, 8'd7);
    op(1'b0, 32'd200, 32'd7, e8.q, e8.r, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
